// File: rtl/flash_page_sequencer.sv
// -----------------------------------------------------------------------------
// flash_page_sequencer
//
// Command front-end for the flash controller stage. Each accepted command
// resets the controller FIFO pair, waits for the FIFOs to settle, optionally
// streams one page of program data into the write FIFO, fires exactly one
// one-cycle controller strobe (era / wr_flash / rd_flash), waits for the
// matching completion event (bounded by a timeout), drains the read FIFO to
// the sink for reads, and finally reports cmd_done or cmd_err for one cycle.
//
// Ports
//   clk, rst_n                    core clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only when idle)
//   cmd_op, cmd_row               0 erase, 1 program, 2 read, 3 rejected; row
//   src_data/src_valid/src_ready  program data stream in
//   snk_data/snk_valid, snk_ready read data stream out (no backpressure on
//                                 returned words; snk_ready gates the pops)
//   fifo_rst, wr_fifo, fifo_din   controller FIFO reset and write-FIFO push
//   rd_fifo, fifo_dout, fifo_valid read-FIFO pop and returned data
//   era, wr_flash, rd_flash, row  controller command strobes and target row
//   busy, done_toe, done_move     controller status and completion events
//   cmd_done, cmd_err, err_code   completion pulses; err_code held until the
//                                 next accepted command
// -----------------------------------------------------------------------------
module flash_page_sequencer #(
   parameter int PAGE_WORDS   = 512,
   parameter int RD_WORDS     = 512,
   parameter int FIFO_RST_CYC = 8,
   parameter int SETTLE_CYC   = 4,
   parameter int TIMEOUT_CYC  = 16777215
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [13:0] cmd_row,
   input  logic [15:0] src_data,
   input  logic        src_valid,
   output logic        src_ready,
   output logic [15:0] snk_data,
   output logic        snk_valid,
   input  logic        snk_ready,
   output logic        fifo_rst,
   output logic        wr_fifo,
   output logic [15:0] fifo_din,
   output logic        rd_fifo,
   input  logic [15:0] fifo_dout,
   input  logic        fifo_valid,
   output logic        era,
   output logic        wr_flash,
   output logic        rd_flash,
   output logic [13:0] row,
   input  logic        busy,
   input  logic        done_toe,
   input  logic        done_move,
   output logic        cmd_done,
   output logic        cmd_err,
   output logic [1:0]  err_code
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FRST   = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_LOAD   = 3'd3;
   localparam logic [2:0] S_KICK   = 3'd4;
   localparam logic [2:0] S_WAIT   = 3'd5;
   localparam logic [2:0] S_DRAIN  = 3'd6;
   localparam logic [2:0] S_FIN    = 3'd7;

   localparam logic [1:0] OP_ERASE = 2'd0;
   localparam logic [1:0] OP_PROG  = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;
   localparam logic [1:0] OP_BAD   = 2'd3;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_OP      = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   localparam logic [10:0] PAGE_N      = 11'(PAGE_WORDS);
   localparam logic [10:0] RD_N        = 11'(RD_WORDS);
   localparam logic [10:0] FRST_LAST   = 11'(FIFO_RST_CYC - 1);
   localparam logic [10:0] SETTLE_LAST = 11'(SETTLE_CYC - 1);
   localparam logic [23:0] TO_LAST     = 24'(TIMEOUT_CYC - 1);

   logic [2:0]  state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [13:0] row_q, row_d;
   logic [10:0] cnt_q, cnt_d;   // phase cycles, pushed words, or issued pops
   logic [10:0] ret_q, ret_d;   // read words returned to the sink
   logic [23:0] to_q, to_d;
   logic        err_q, err_d;
   logic [1:0]  code_q, code_d;
   logic        move_prev_q;

   logic        move_rise;
   logic        complete;

   // busy is informational only; completion is taken from the done events.
   logic unused_busy;
   assign unused_busy = busy;

   // done_move is stretched over two cycles; only its first cycle counts.
   assign move_rise = done_move & ~move_prev_q;
   assign complete  = (op_q == OP_READ) ? move_rise : done_toe;

   // Moore-style outputs decoded from the state; the data paths are
   // combinational pass-through, gated so nothing leaks outside their phase.
   assign cmd_ready = (state_q == S_IDLE);
   assign fifo_rst  = (state_q == S_FRST);
   assign src_ready = (state_q == S_LOAD) && (cnt_q < PAGE_N);
   assign wr_fifo   = src_ready & src_valid;
   assign fifo_din  = wr_fifo ? src_data : 16'd0;
   assign rd_fifo   = (state_q == S_DRAIN) && snk_ready && (cnt_q < RD_N);
   assign snk_valid = (state_q == S_DRAIN) && fifo_valid && (ret_q < RD_N);
   assign snk_data  = snk_valid ? fifo_dout : 16'd0;
   assign era       = (state_q == S_KICK) && (op_q == OP_ERASE);
   assign wr_flash  = (state_q == S_KICK) && (op_q == OP_PROG);
   assign rd_flash  = (state_q == S_KICK) && (op_q == OP_READ);
   assign row       = row_q;
   assign cmd_done  = (state_q == S_FIN) && !err_q;
   assign cmd_err   = (state_q == S_FIN) && err_q;
   assign err_code  = code_q;

   always_comb begin
      // NOTE: every next-state signal is given a hold default before the case,
      // so no branch can leave one unassigned and infer a latch.
      state_d = state_q;
      op_d    = op_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      ret_d   = ret_q;
      to_d    = to_q;
      err_d   = err_q;
      code_d  = code_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               row_d  = cmd_row;
               op_d   = cmd_op;
               cnt_d  = '0;
               code_d = ERR_NONE;
               if (cmd_op == OP_BAD) begin
                  state_d = S_FIN;
                  err_d   = 1'b1;
                  code_d  = ERR_OP;
               end else begin
                  state_d = S_FRST;
                  err_d   = 1'b0;
               end
            end
         end
         S_FRST: begin
            if (cnt_q == FRST_LAST) begin
               cnt_d   = '0;
               state_d = S_SETTLE;
            end else begin
               cnt_d = cnt_q + 11'd1;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = (op_q == OP_PROG) ? S_LOAD : S_KICK;
            end else begin
               cnt_d = cnt_q + 11'd1;
            end
         end
         S_LOAD: begin
            // Leaving on the last push drops src_ready in the very next cycle.
            if (wr_fifo) begin
               cnt_d = cnt_q + 11'd1;
               if ((cnt_q + 11'd1) == PAGE_N) begin
                  state_d = S_KICK;
               end
            end
         end
         S_KICK: begin
            to_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            to_d = to_q + 24'd1;
            // Completion is checked first so it wins over the terminal count.
            if (complete) begin
               if (op_q == OP_READ) begin
                  state_d = S_DRAIN;
                  cnt_d   = '0;
                  ret_d   = '0;
               end else begin
                  state_d = S_FIN;
               end
            end else if (to_q == TO_LAST) begin
               state_d = S_FIN;
               err_d   = 1'b1;
               code_d  = ERR_TIMEOUT;
            end
         end
         S_DRAIN: begin
            if (rd_fifo) begin
               cnt_d = cnt_q + 11'd1;
            end
            if (snk_valid) begin
               ret_d = ret_q + 11'd1;
            end
            if ((cnt_d == RD_N) && (ret_d == RD_N)) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: registers are updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= OP_ERASE;
         row_q       <= '0;
         cnt_q       <= '0;
         ret_q       <= '0;
         to_q        <= '0;
         err_q       <= 1'b0;
         code_q      <= ERR_NONE;
         move_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         ret_q       <= ret_d;
         to_q        <= to_d;
         err_q       <= err_d;
         code_q      <= code_d;
         move_prev_q <= done_move;
      end
   end

endmodule
